// File: rtl/st_merger16.sv
// st_merger16: two-input Avalon-ST packet merger (16-bit data, 1-bit empty).
// A packet is forwarded whole; a source holds the output until its
// endofpacket beat is accepted. Ties in IDLE go to the input that did not
// win last time. All out_* signals come from one register stage.
// Ports:
//   st_merger16_clk_clk / st_merger16_reset_reset_n : clock, async active-low reset
//   st_merger16_in0_* / st_merger16_in1_*           : Avalon-ST sinks (readyLatency 0)
//   st_merger16_out_*                               : Avalon-ST source, out_channel = source index
module st_merger16 #(
  localparam int unsigned DATA_W = 16
) (
  input  logic              st_merger16_clk_clk,
  input  logic              st_merger16_reset_reset_n,
  output logic              st_merger16_in0_ready,
  input  logic              st_merger16_in0_valid,
  input  logic              st_merger16_in0_startofpacket,
  input  logic              st_merger16_in0_endofpacket,
  input  logic              st_merger16_in0_empty,
  input  logic [DATA_W-1:0] st_merger16_in0_data,
  output logic              st_merger16_in1_ready,
  input  logic              st_merger16_in1_valid,
  input  logic              st_merger16_in1_startofpacket,
  input  logic              st_merger16_in1_endofpacket,
  input  logic              st_merger16_in1_empty,
  input  logic [DATA_W-1:0] st_merger16_in1_data,
  input  logic              st_merger16_out_ready,
  output logic              st_merger16_out_valid,
  output logic              st_merger16_out_startofpacket,
  output logic              st_merger16_out_endofpacket,
  output logic              st_merger16_out_empty,
  output logic [DATA_W-1:0] st_merger16_out_data,
  output logic              st_merger16_out_channel
);

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic              empty;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  logic  clk;
  logic  rst_n;
  assign clk   = st_merger16_clk_clk;
  assign rst_n = st_merger16_reset_reset_n;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  beat_t  out_q;
  logic   out_valid_q;
  logic   out_channel_q;

  logic   load_c;
  logic   grant_vld_c;
  logic   grant_c;
  logic   sel_c;
  logic   rdy0_c, rdy1_c;
  logic   accept_c;
  beat_t  in0_beat_c, in1_beat_c, beat_c;

  assign in0_beat_c = '{sop: st_merger16_in0_startofpacket, eop: st_merger16_in0_endofpacket,
                        empty: st_merger16_in0_empty, data: st_merger16_in0_data};
  assign in1_beat_c = '{sop: st_merger16_in1_startofpacket, eop: st_merger16_in1_endofpacket,
                        empty: st_merger16_in1_empty, data: st_merger16_in1_data};

  // Arbitration, ready generation and next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    load_c       = !out_valid_q || st_merger16_out_ready;
    grant_vld_c  = st_merger16_in0_valid || st_merger16_in1_valid;
    // Tie goes to the input opposite the last winner; otherwise to whoever is valid
    grant_c      = (st_merger16_in0_valid && st_merger16_in1_valid) ? !last_grant_q
                                                                    : st_merger16_in1_valid;
    unique case (state_q)
      LOCK0:   sel_c = 1'b0;
      LOCK1:   sel_c = 1'b1;
      default: sel_c = grant_c;
    endcase
    // rst_n term keeps both readies low while reset is held
    rdy0_c   = rst_n && load_c &&
               ((state_q == LOCK0) || ((state_q == IDLE) && grant_vld_c && !grant_c));
    rdy1_c   = rst_n && load_c &&
               ((state_q == LOCK1) || ((state_q == IDLE) && grant_vld_c && grant_c));
    accept_c = (rdy0_c && st_merger16_in0_valid) || (rdy1_c && st_merger16_in1_valid);
    beat_c   = sel_c ? in1_beat_c : in0_beat_c;
    if (accept_c) begin
      if (beat_c.eop) begin
        state_d      = IDLE;
        last_grant_d = sel_c;
      end else begin
        state_d = sel_c ? LOCK1 : LOCK0;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output register stage; holds under backpressure, empties when drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= 1'b0;
    end else if (accept_c) begin
      out_q         <= beat_c;
      out_valid_q   <= 1'b1;
      out_channel_q <= sel_c;
    end else if (st_merger16_out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign st_merger16_in0_ready         = rdy0_c;
  assign st_merger16_in1_ready         = rdy1_c;
  assign st_merger16_out_valid         = out_valid_q;
  assign st_merger16_out_startofpacket = out_q.sop;
  assign st_merger16_out_endofpacket   = out_q.eop;
  assign st_merger16_out_empty         = out_q.empty;
  assign st_merger16_out_data          = out_q.data;
  assign st_merger16_out_channel       = out_channel_q;

endmodule

// File: doc/st_merger16.md
ST_MERGER16 -- requirements
Module: st_merger16

Interface
REQ-001 SHALL have no parameters; data width fixed at 16 bits, empty width fixed at 1 bit.
REQ-002 SHALL provide port st_merger16_clk_clk, input, 1 bit: single clock, all logic rising-edge.
REQ-003 SHALL provide port st_merger16_reset_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL provide ports st_merger16_in0_ready (output, 1), _in0_valid (input, 1), _in0_startofpacket (input, 1), _in0_endofpacket (input, 1), _in0_empty (input, 1), _in0_data (input, 16): Avalon-ST sink 0.
REQ-005 SHALL provide the same set for st_merger16_in1_*: Avalon-ST sink 1.
REQ-006 SHALL provide st_merger16_out_ready (input, 1), _out_valid, _out_startofpacket, _out_endofpacket (outputs, 1), _out_empty (output, 1), _out_data (output, 16), _out_channel (output, 1, source index of the beat): Avalon-ST source.

Function
REQ-007 SHALL merge two packet streams into one, readyLatency 0 on all ports; a beat transfers on a port only in cycles where ready and valid are both high.
REQ-008 SHALL register all out_* signals in one output stage; latency from accepted input beat to out_valid = 1 cycle.
REQ-009 SHALL define load = (!out_valid || out_ready); the output register loads only when load=1 and a beat is accepted.
REQ-010 SHALL implement states IDLE, LOCK0, LOCK1 plus a 1-bit last_grant register.
REQ-011 In IDLE SHALL pick grant combinationally: only in0 valid -> 0; only in1 valid -> 1; both valid -> input opposite to last_grant; neither -> no grant.
REQ-012 SHALL drive inX_ready = load AND (state==LOCKX OR (state==IDLE AND grant==X)); the non-granted input's ready SHALL be 0.
REQ-013 On an accepted beat with endofpacket=0 from IDLE, SHALL move to LOCKX for source X.
REQ-014 In LOCKX SHALL accept beats only from input X until its endofpacket beat is accepted, ignoring the other input's valid.
REQ-015 On accepting an endofpacket beat (including a sop+eop single-beat packet in IDLE), SHALL go to IDLE and set last_grant = X in the same edge.
REQ-016 SHALL copy data, empty, startofpacket, endofpacket unchanged into the output register and set out_channel = X.
REQ-017 SHALL not check sop framing: a beat accepted in IDLE without sop is forwarded as-is and locks as in REQ-013.
REQ-018 SHALL hold out_* stable while out_valid=1 and out_ready=0 (backpressure); with load=0 both in*_ready SHALL be 0.
REQ-019 SHALL sustain one beat per cycle when out_ready is held high, including back-to-back packets from alternating sources with no idle cycle.
REQ-020 SHALL clear out_valid on a cycle where out_ready=1 and no input beat is accepted.

Reset
REQ-021 While st_merger16_reset_reset_n=0, SHALL force out_valid=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, out_data=0x0000, out_channel=0, state=IDLE, last_grant=1 (in0 wins first tie).
REQ-022 SHALL assert reset asynchronously; an in-flight packet is dropped, no partial-packet recovery; in*_ready=0 during reset.
REQ-023 SHALL resume normal operation on the first rising edge after deassertion.

Verification
REQ-024 Reset then both inputs valid with 1-beat packets (0xAAAA ch0, 0x5555 ch1), out_ready=1 -> out shows 0xAAAA/ch0 then 0x5555/ch1 on consecutive cycles.
REQ-025 in0 sends 4-beat packet 0x0001..0x0004 while in1 holds valid from beat 2 -> in1_ready=0 until in0 eop accepted; in1 packet follows with no gap.
REQ-026 out_ready=0 for 3 cycles mid-packet -> out_data/out_valid unchanged, both in*_ready=0, no beat lost or duplicated.
REQ-027 Both inputs stream continuous 2-beat packets for 20 cycles -> strict alternation ch0,ch1,ch0,...; throughput 1 beat/cycle.
REQ-028 Assert reset in LOCK1 mid-packet -> out_valid=0 immediately; after release, in0 and in1 both valid -> in0 granted first.
REQ-029 Single-beat packet with empty=1 on in1 -> out_empty=1, sop=1, eop=1, out_channel=1, state returns to IDLE.
